// File: rtl/reg_serie_con_carga_paralela_pkg.sv
// Shared constants for the parallel-load / serial-out register.
// Mode encodings for LS and the default register length.
package reg_serie_pkg;

    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_SHIFT = 1'b1;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/reg_serie_con_carga_paralela_cell.sv
// One bit-slice of the PISO register.
// Mux between parallel bit and shift input, flop with sync clear.
module reg_serie_cell
    import reg_serie_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ls,
    input  logic dp_bit,
    input  logic shift_in,
    output logic q
);

    // Clear dominates; otherwise load the parallel bit or take the upper neighbour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (ls == LS_LOAD) begin
            q <= dp_bit;
        end else begin
            q <= shift_in;
        end
    end

endmodule

// File: rtl/reg_serie_con_carga_paralela.sv
// WIDTH-bit shift register with parallel load, serial LSB-first output.
// A chain of bit-slices; D feeds the top slice, out is slice 0.
module reg_serie_con_carga_paralela
    import reg_serie_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LS,
    input  logic             D,
    input  logic [WIDTH-1:0] DP,
    output logic             out
);

    logic [WIDTH-1:0] q;

    // Each slice shifts in from its upper neighbour; the top slice takes D.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == WIDTH - 1) begin : g_top
            reg_serie_cell u_cell (
                .clk      (clk),
                .rst      (rst),
                .ls       (LS),
                .dp_bit   (DP[i]),
                .shift_in (D),
                .q        (q[i])
            );
        end else begin : g_mid
            reg_serie_cell u_cell (
                .clk      (clk),
                .rst      (rst),
                .ls       (LS),
                .dp_bit   (DP[i]),
                .shift_in (q[i+1]),
                .q        (q[i])
            );
        end
    end

    assign out = q[0];

endmodule

// File: tb/tb_reg_serie_con_carga_paralela.sv
// Self-checking bench for the PISO register.
// Directed scenarios plus random traffic against a word-level model.
module tb_reg_serie_con_carga_paralela;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         LS;
    logic         D;
    logic [W-1:0] DP;
    logic         out;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] model;
    bit           chk_en = 1'b0;

    reg_serie_con_carga_paralela #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .LS  (LS),
        .D   (D),
        .DP  (DP),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Word-level reference: reset clears, load copies DP,
    // shift divides by two and inserts D as the new top bit.
    always @(posedge clk) begin
        if (rst === 1'b0)
            model <= '0;
        else if (LS === 1'b0)
            model <= DP;
        else
            model <= W'((int'(model) / 2) + (int'(D) << (W - 1)));
        chk_en <= 1'b1;
    end

    // Outputs are compared against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out", 32'(out), 32'(model[0]));
            chk("cyc_q", 32'(dut.q), 32'(model));
        end
    end

    task automatic cyc(input logic r, input logic l, input logic d,
                       input logic [W-1:0] dp);
        rst = r;
        LS  = l;
        D   = d;
        DP  = dp;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [W-1:0] qexp,
                       input logic oexp);
        chk({name, "_q"}, 32'(dut.q), 32'(qexp));
        chk({name, "_out"}, 32'(out), 32'(oexp));
        chk({name, "_model"}, 32'(model), 32'(qexp));
    endtask

    initial begin
        logic [4:0] t3;
        logic [3:0] t4;
        rst = 1'b0; LS = 1'b0; D = 1'b0; DP = '0;

        // Reset suppresses a load.
        cyc(0, 0, 0, 4'd5);
        cyc(0, 0, 0, 4'd5);
        lit("t1_reset", 4'b0000, 1'b0);

        // Parallel loads.
        cyc(1, 0, 0, 4'd8);
        lit("t2_load8", 4'b1000, 1'b0);
        cyc(1, 0, 0, 4'd11);
        lit("t2_load11", 4'b1011, 1'b1);

        // Shift out 1011 with D=0.
        t3 = 5'b00101;
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 0, 4'd0);
            chk("t3_out", 32'(out), 32'(t3[k]));
        end
        lit("t3_final", 4'b0000, 1'b0);

        // Serial fill with ones.
        t4 = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 1, 4'd0);
            chk("t4_out", 32'(out), 32'(t4[k]));
        end
        lit("t4_fill", 4'b1111, 1'b1);

        // Reset in the middle of shifting.
        cyc(1, 0, 0, 4'b1011);
        cyc(0, 1, 1, 4'b1111);
        lit("t5_rst", 4'b0000, 1'b0);
        cyc(1, 1, 1, 4'b1111);
        lit("t5_resume", 4'b1000, 1'b0);

        // Mode switch.
        cyc(1, 0, 0, 4'b0110);
        cyc(1, 1, 1, 4'b0000);
        lit("t6_shift", 4'b1011, 1'b1);
        cyc(1, 0, 0, 4'b0001);
        lit("t6_load", 4'b0001, 1'b1);

        // Random traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 19) != 0),
                logic'($urandom_range(0, 2) != 0),
                logic'($urandom_range(0, 1)),
                W'($urandom));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
